// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the delay-line consumer FIFO.
// The optional overflow flag is enabled with PIPELINE_CREDIT_FIFO_OVERFLOW_EN.
package pipeline_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_LATENCY = 8;

    localparam int PTR_W = clog2(DEF_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic push;
        logic pop;
    } fifo_op_t;

endpackage

// File: rtl/pipeline_credit_fifo_credit_counter.sv
// In-flight word counter and credit compare for pipeline_credit_fifo.
// With PIPELINE_CREDIT_FIFO_OVERFLOW_EN it also reports arrivals with nothing in flight.
module credit_counter
    import pipeline_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LW    = clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_req,
    input  logic          in_valid,
    input  logic [LW-1:0] level,
    output logic          issue_ok
`ifdef PIPELINE_CREDIT_FIFO_OVERFLOW_EN
    ,
    output logic          underrun
`endif
);

    localparam logic [LW:0] LIMIT = DEPTH[LW:0];

    logic [LW-1:0] infl;
    logic [LW-1:0] infl_nxt;
    logic [LW:0]   used;
    logic          accept;

    // Registered state only, so issue_req never loops back into issue_ok.
    assign used     = {1'b0, level} + {1'b0, infl};
    assign issue_ok = used < LIMIT;
    assign accept   = issue_req & issue_ok;

`ifdef PIPELINE_CREDIT_FIFO_OVERFLOW_EN
    assign underrun = in_valid & (infl == '0);
`endif

    always_comb begin
        infl_nxt = infl;
        if (accept && !in_valid)
            infl_nxt = infl + 1'b1;
        else if (!accept && in_valid && infl != '0)
            infl_nxt = infl - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) infl <= '0;
        else        infl <= infl_nxt;
    end

endmodule

// File: rtl/pipeline_credit_fifo.sv
// Credit-throttled first-word fall-through FIFO behind the fixed-latency delay line.
// Define PIPELINE_CREDIT_FIFO_OVERFLOW_EN to add the sticky overflow output.
module pipeline_credit_fifo
    import pipeline_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_req,
    output logic                   issue_ok,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [clog2(DEPTH):0]  level
`ifdef PIPELINE_CREDIT_FIFO_OVERFLOW_EN
    ,
    output logic                   overflow
`endif
);

    localparam int PW = clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = DEPTH[LW-1:0];

    if (LATENCY > DEPTH || DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_cfg
        $error("pipeline_credit_fifo: bad DEPTH/LATENCY combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    fifo_op_t         op;

    assign full      = (level == FULL_LVL);
    assign out_valid = (level != '0);
    assign op.pop    = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push lands in.
    assign op.push   = in_valid & (!full | op.pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

`ifdef PIPELINE_CREDIT_FIFO_OVERFLOW_EN
    logic underrun;

    credit_counter #(.DEPTH(DEPTH), .LW(LW)) u_credit (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_req(issue_req),
        .in_valid (in_valid),
        .level    (level),
        .issue_ok (issue_ok),
        .underrun (underrun)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if ((in_valid & full & !op.pop) | underrun)
            overflow <= 1'b1;
    end
`else
    credit_counter #(.DEPTH(DEPTH), .LW(LW)) u_credit (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_req(issue_req),
        .in_valid (in_valid),
        .level    (level),
        .issue_ok (issue_ok)
    );
`endif

    always_ff @(posedge clk) begin
        if (op.push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (op.push) wr_ptr <= wr_ptr + 1'b1;
            if (op.pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({op.push, op.pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule
